// File: rtl/cska_adder.sv
// cska_adder -- N-bit carry-skip adder with a registered result.
//
// Computes {Cout,Sum} <= A + B + Cin on every rising clk edge (1-cycle latency).
// Operands are cut into BLOCK_SIZE-bit ripple blocks. When every bit of a block
// propagates, the block carry-in is muxed straight to the block carry-out.
//
// Ports:
//   clk   in  1  clock, rising edge
//   rst   in  1  synchronous active-high reset, clears Sum and Cout
//   A     in  N  operand A, unsigned
//   B     in  N  operand B, unsigned
//   Cin   in  1  carry into bit 0
//   Sum   out N  registered (A+B+Cin) mod 2^N
//   Cout  out 1  registered carry out of bit N-1

// cska_block -- one W-bit ripple block with a skip mux on its carry-out.
//
// Ports:
//   a, b  in  W  operand slices
//   ci    in  1  block carry-in
//   s     out W  sum slice
//   co    out 1  block carry-out (skipped when the whole block propagates)
module cska_block #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);
   logic [W-1:0] p, g;
   logic [W:0]   c;

   assign p    = a ^ b;
   assign g    = a & b;
   assign c[0] = ci;

   for (genvar i = 0; i < W; i++) begin : g_rip
      assign c[i+1] = g[i] | (p[i] & c[i]);
   end

   assign s  = p ^ c[W-1:0];
   // All-propagate means c[W] == ci anyway; the mux only shortens the path.
   assign co = (&p) ? ci : c[W];
endmodule

module cska_adder #(
   parameter int N          = 2,
   parameter int BLOCK_SIZE = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Cin,
   output logic [N-1:0] Sum,
   output logic         Cout
);
   localparam int NB = (N + BLOCK_SIZE - 1) / BLOCK_SIZE;

   logic [NB:0]  bc;       // block carry chain, bc[0] = Cin
   logic [N-1:0] sum_nxt;

   assign bc[0] = Cin;

   for (genvar k = 0; k < NB; k++) begin : g_blk
      localparam int LO = k * BLOCK_SIZE;
      // Last block is narrower when N is not a multiple of BLOCK_SIZE.
      localparam int W  = ((N - LO) < BLOCK_SIZE) ? (N - LO) : BLOCK_SIZE;

      cska_block #(.W(W)) u_blk (
         .a  (A[LO +: W]),
         .b  (B[LO +: W]),
         .ci (bc[k]),
         .s  (sum_nxt[LO +: W]),
         .co (bc[k+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Sum  <= '0;
         Cout <= 1'b0;
      end else begin
         Sum  <= sum_nxt;
         Cout <= bc[NB];
      end
   end
endmodule

// File: tb/tb_cska_adder.sv
// tb_cska_adder -- directed and sweep checks of cska_adder.
// Two instances: N=2/BLOCK_SIZE=2 and N=5/BLOCK_SIZE=2 (partial last block).
module tb_cska_adder;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] a2, b2, s2;
   logic       c2, co2;
   logic [4:0] a5, b5, s5;
   logic       c5, co5;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cska_adder #(.N(2), .BLOCK_SIZE(2)) u_d2 (
      .clk(clk), .rst(rst), .A(a2), .B(b2), .Cin(c2), .Sum(s2), .Cout(co2)
   );

   cska_adder #(.N(5), .BLOCK_SIZE(2)) u_d5 (
      .clk(clk), .rst(rst), .A(a5), .B(b5), .Cin(c5), .Sum(s5), .Cout(co5)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one N=2 operation, clock it, check the registered result.
   task automatic op2(input string tag, input logic [1:0] a, input logic [1:0] b,
                      input logic c, input logic [1:0] es, input logic ec);
      a2 = a; b2 = b; c2 = c;
      @(posedge clk); #1;
      chk({tag, " sum"},  32'(s2),  32'(es));
      chk({tag, " cout"}, 32'(co2), 32'(ec));
   endtask

   // back-to-back table: a, b, cin, expected {cout,sum}
   logic [1:0] bb_a [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
   logic [1:0] bb_b [4] = '{2'b01, 2'b11, 2'b00, 2'b01};
   logic       bb_c [4] = '{1'b0,  1'b1,  1'b1,  1'b0};
   logic [2:0] bb_e [4] = '{3'b010, 3'b111, 3'b011, 3'b001};

   initial begin
      logic [2:0] prev;
      rst = 1'b1;
      a2 = 2'b11; b2 = 2'b11; c2 = 1'b1;
      a5 = 5'h1f; b5 = 5'h1f; c5 = 1'b1;

      // reset held two cycles with live operands
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("reset sum2",  32'(s2),  32'd0);
         chk("reset cout2", 32'(co2), 32'd0);
         chk("reset out5",  32'({co5, s5}), 32'd0);
      end
      rst = 1'b0;
      op2("rst_release", 2'b11, 2'b11, 1'b1, 2'b11, 1'b1);

      op2("cin_only",   2'b00, 2'b00, 1'b1, 2'b01, 1'b0);
      op2("b01_cin",    2'b00, 2'b01, 1'b1, 2'b10, 1'b0);
      op2("b10",        2'b00, 2'b10, 1'b0, 2'b10, 1'b0);
      op2("skip",       2'b11, 2'b00, 1'b1, 2'b00, 1'b1);
      op2("no_prop",    2'b10, 2'b01, 1'b0, 2'b11, 1'b0);
      op2("overflow",   2'b10, 2'b10, 1'b1, 2'b01, 1'b1);
      op2("all_zero",   2'b00, 2'b00, 1'b0, 2'b00, 1'b0);

      // back-to-back: output must hold the previous result until the next edge
      prev = 3'b000;
      for (int i = 0; i < 4; i++) begin
         a2 = bb_a[i]; b2 = bb_b[i]; c2 = bb_c[i];
         #1;
         chk("b2b hold", 32'({co2, s2}), 32'(prev));
         @(posedge clk); #1;
         chk("b2b new",  32'({co2, s2}), 32'(bb_e[i]));
         prev = bb_e[i];
      end

      // reset mid-stream with nonzero operands
      a2 = 2'b11; b2 = 2'b10; c2 = 1'b1;
      a5 = 5'd20; b5 = 5'd30; c5 = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst out2", 32'({co2, s2}), 32'd0);
      chk("mid_rst out5", 32'({co5, s5}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("after_rst out2", 32'({co2, s2}), 32'b110);   // 3+2+1 = 6
      chk("after_rst out5", 32'({co5, s5}), 32'd51);    // 20+30+1

      // exhaustive N=5 (drives all N=2 vectors along the way)
      for (int a = 0; a < 32; a++)
         for (int b = 0; b < 32; b++)
            for (int c = 0; c < 2; c++) begin
               a5 = 5'(a); b5 = 5'(b); c5 = c[0];
               a2 = 2'(a); b2 = 2'(b); c2 = c[0];
               @(posedge clk); #1;
               chk("exh5", 32'({co5, s5}), 32'(a + b + c));
               chk("exh2", 32'({co2, s2}), 32'((a % 4) + (b % 4) + c));
            end

      // random
      for (int i = 0; i < 1000; i++) begin
         int a, b, c;
         a = int'($urandom_range(31));
         b = int'($urandom_range(31));
         c = int'($urandom_range(1));
         a5 = 5'(a); b5 = 5'(b); c5 = c[0];
         @(posedge clk); #1;
         chk("rand5", 32'({co5, s5}), 32'(a + b + c));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
